// File: rtl/mc_controller.sv
// Multicycle RV32 control FSM, Moore outputs, 3-5 cycles per instruction; MC_CTRL_MEM_WAIT_EN
// makes FETCH/MEMREAD/MEMWRITE stall on mem_ready, otherwise mem_ready is ignored.
module mc_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_TRAP
  } state_t;

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       mem_ok;
  logic       pc_we, ir_we, reg_we, mem_we;
  logic [2:0] alu_dec;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ok) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ok) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ok) state_d = S_FETCH;
      S_MEMWB, S_ALUWB, S_BRANCH, S_LUI: state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL:           state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
    // Sticky: set on the edge that enters TRAP, cleared only by reset.
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (state_q == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_STORE:  ImmSrc = 3'b001;
      OP_BRANCH: ImmSrc = 3'b010;
      OP_LUI:    ImmSrc = 3'b011;
      OP_JAL:    ImmSrc = 3'b100;
      default:   ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    mem_we     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ir_we     = mem_ok;
        pc_we     = mem_ok;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_we    = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_we = mem_ok;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec;
      end
      S_ALUWB:    reg_we = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        pc_we      = zero ^ funct3[0];
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_we   = 1'b1;
      end
      S_LUI: begin
        ResultSrc = 2'b11;
        reg_we    = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are gated by rst_n so they drop the instant reset asserts.
  assign PCWrite  = pc_we & rst_n;
  assign IRWrite  = ir_we & rst_n;
  assign RegWrite = reg_we & rst_n;
  assign MemWrite = mem_we & rst_n;
  assign illegal  = illegal_q;

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: op  in  7  instr[6:0]; funct3  in  3  instr[14:12]; funct7b5  in  1  instr[30].
REQ-004 SHALL have port: zero  in  1  ALU zero flag; mem_ready  in  1  memory handshake (see Configuration).
REQ-005 SHALL have port: PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc  out  1 each  datapath enables/select.
REQ-006 SHALL have port: ALUSrcA, ALUSrcB, ResultSrc  out  2 each; ALUControl  out  3; ImmSrc  out  3.
REQ-007 SHALL have port: illegal  out  1  sticky unsupported-opcode flag.

Function
REQ-008 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, TRAP; state register updates on clk rising edge.
REQ-009 Transitions SHALL be: FETCH->DECODE; DECODE->MEMADR (0000011, 0100011), EXECR (0110011), EXECI (0010011), BRANCH (1100011), JAL (1101111), LUI (0110111), else TRAP; MEMADR->MEMREAD (load) or MEMWRITE (store); MEMREAD->MEMWB; EXECR/EXECI/JAL->ALUWB; MEMWB, MEMWRITE, ALUWB, BRANCH, LUI->FETCH; TRAP->TRAP.
REQ-010 Instruction latency SHALL be: load 5, store 4, R/I-ALU 4, branch 3, jal 4, lui 3 cycles (no wait states).
REQ-011 ImmSrc SHALL be driven from op in every state: I 000 (load, I-ALU), S 001, B 010, U 011, J 100, else 000.
REQ-012 FETCH SHALL assert AdrSrc=0, IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALU add.
REQ-013 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ALU add (branch target precompute).
REQ-014 MEMADR/EXECI SHALL drive ALUSrcA=10, ALUSrcB=01; EXECR ALUSrcA=10, ALUSrcB=00.
REQ-015 MEMREAD SHALL drive AdrSrc=1, ResultSrc=00; MEMWRITE AdrSrc=1, MemWrite=1, ResultSrc=00.
REQ-016 MEMWB SHALL drive ResultSrc=01, RegWrite=1; ALUWB ResultSrc=00, RegWrite=1; LUI ResultSrc=11, RegWrite=1.
REQ-017 BRANCH SHALL drive ALUSrcA=10, ALUSrcB=00, ALU sub, ResultSrc=00, PCWrite = zero XOR funct3[0] (beq/bne).
REQ-018 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1, ALU add.
REQ-019 ALUControl in EXECR/EXECI SHALL decode funct3: 000 add (sub if EXECR and funct7b5), 010 slt 101, 110 or 011, 111 and 010; other funct3 add 000; sub encodes 001.
REQ-020 Signals not listed for a state SHALL be 0.
REQ-021 TRAP SHALL hold all enables 0 and illegal=1 until reset.

Reset
REQ-022 rst_n low SHALL immediately force state=FETCH and illegal=0, independent of clk.
REQ-023 While rst_n low, PCWrite, IRWrite, RegWrite, MemWrite SHALL be 0; other outputs take FETCH values.
REQ-024 Reset mid-instruction SHALL abandon it; first post-reset edge stays in FETCH only if mem wait applies, else goes to DECODE.

Configuration
REQ-025 Macro MC_CTRL_MEM_WAIT_EN defined: FETCH, MEMREAD, MEMWRITE SHALL hold state and outputs until mem_ready=1; IRWrite, PCWrite (FETCH) and MemWrite SHALL assert only in the cycle mem_ready=1.
REQ-026 Macro undefined: mem_ready SHALL be ignored and every state lasts exactly one cycle.

Verification
REQ-027 add x3,x1,x2 (op 0110011, f3 000, f7b5 0) -> FETCH,DECODE,EXECR,ALUWB; ALUControl 000, RegWrite=1 in cycle 4 only.
REQ-028 lw (0000011) -> 5 states ending MEMWB, ImmSrc=000, ResultSrc=01 in MEMWB; sw (0100011) -> MemWrite=1 in cycle 4, ImmSrc=001.
REQ-029 beq with zero=1 -> PCWrite=1 in BRANCH; bne (f3 001) with zero=1 -> PCWrite=0; ImmSrc=010.
REQ-030 op 1111111 -> TRAP after DECODE, illegal=1, all enables 0 for 10 cycles; rst_n pulse clears illegal, state FETCH.
REQ-031 MC_CTRL_MEM_WAIT_EN defined, lw with mem_ready low 3 cycles in MEMREAD -> load latency 8, no spurious IRWrite/PCWrite.
REQ-032 rst_n asserted mid-MEMWRITE between edges -> MemWrite drops to 0 combinationally, state FETCH.
